// File: rtl/sr_mdu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sr_mdu_arbiter
// Description : Shares one non-pipelined multiply/divide unit between two
//               requesters. Round-robin arbitration, one operation in flight,
//               per-operation timeout and owner-initiated cancel.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      clock
//   reset_n      in   1      synchronous active-low reset
//   req_vld[i]   in   1      requester i presents an operation
//   req_rdy[i]   out  1      requester i's operation is accepted this cycle
//   req_a[i]     in   WIDTH  operand A of requester i
//   req_b[i]     in   WIDTH  operand B of requester i
//   req_op[i]    in   3      MDU opcode of requester i
//   req_clr[i]   in   1      requester i cancels its outstanding operation
//   rsp_vld[i]   out  1      one-cycle response strobe to requester i
//   rsp_data     out  WIDTH  response data (shared)
//   rsp_err      out  1      response is a timeout abort
//   mdu_srcA     out  WIDTH  operand A to the MDU
//   mdu_srcB     out  WIDTH  operand B to the MDU
//   mdu_op       out  3      opcode to the MDU
//   mdu_vld_in   out  1      start strobe to the MDU
//   mdu_clear    out  1      abort strobe to the MDU
//   mdu_res      in   WIDTH  MDU result
//   mdu_vld_out  in   1      MDU result valid
//   busy         out  1      arbiter is not idle
// ============================================================================
module sr_mdu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_vld,
    output logic [1:0]            req_rdy,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    input  logic [1:0][2:0]       req_op,
    input  logic [1:0]            req_clr,
    output logic [1:0]            rsp_vld,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      mdu_srcA,
    output logic [WIDTH-1:0]      mdu_srcB,
    output logic [2:0]            mdu_op,
    output logic                  mdu_vld_in,
    output logic                  mdu_clear,
    input  logic [WIDTH-1:0]      mdu_res,
    input  logic                  mdu_vld_out,
    output logic                  busy
);

    // Counter wide enough for the largest legal TIMEOUT (1023).
    localparam int               C_CNT_W   = 10;
    localparam logic [C_CNT_W-1:0] C_TO_LAST = C_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic               pri_q,      pri_d;
    logic               owner_q,    owner_d;
    logic [C_CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0]   a_q,        a_d;
    logic [WIDTH-1:0]   b_q,        b_d;
    logic [2:0]         op_q,       op_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q,  rsp_err_d;
    logic               clear_q,    clear_d;

    logic               winner;
    logic               grant;
    logic               owner_clr;

    // ------------------------------------------------------------------
    // Arbitration: pri only matters when both requesters are valid; a
    // lone requester always wins.
    // ------------------------------------------------------------------
    always_comb begin
        winner = 1'b0;
        if (req_vld == 2'b11) begin
            winner = pri_q;
        end else begin
            winner = req_vld[1];
        end
        // Gated with reset_n so no acceptance is advertised during reset.
        grant     = (state_q == ST_IDLE) && (req_vld != 2'b00) && reset_n;
        owner_clr = req_clr[owner_q];
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pri_d      = pri_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        clear_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    a_d     = req_a[winner];
                    b_d     = req_b[winner];
                    op_d    = req_op[winner];
                    owner_d = winner;
                    pri_d   = ~winner;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (owner_clr) begin
                    clear_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Cancel outranks both a same-cycle result and a timeout.
                if (owner_clr) begin
                    clear_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (mdu_vld_out) begin
                    rsp_data_d = mdu_res;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == C_TO_LAST) begin
                    clear_d    = 1'b1;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pri_q      <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pri_q      <= pri_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            clear_q    <= clear_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. mdu_clear is registered, so it lands in the cycle after the
    // abort decision (IDLE or RESP), never in ISSUE where mdu_vld_in is high.
    // ------------------------------------------------------------------
    always_comb begin
        req_rdy = 2'b00;
        if (grant) begin
            req_rdy = winner ? 2'b10 : 2'b01;
        end
        rsp_vld = 2'b00;
        if (state_q == ST_RESP) begin
            rsp_vld = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign mdu_srcA   = a_q;
    assign mdu_srcB   = b_q;
    assign mdu_op     = op_q;
    assign mdu_vld_in = (state_q == ST_ISSUE);
    assign mdu_clear  = clear_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_mdu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_mdu_arbiter
// Description : Self-checking bench for sr_mdu_arbiter. A transaction driver
//               plays both requesters and the MDU; expected responses and
//               abort strobes are queued with their due cycle and a monitor
//               compares them whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_mdu_arbiter;

    localparam int WIDTH     = 32;
    localparam int TIMEOUT   = 8;
    localparam int M_NORMAL  = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_CANCEL  = 2;

    logic                  clk     = 1'b0;
    logic                  reset_n = 1'b0;
    logic [1:0]            req_vld = '0;
    logic [1:0]            req_clr = '0;
    logic [1:0][WIDTH-1:0] req_a   = '0;
    logic [1:0][WIDTH-1:0] req_b   = '0;
    logic [1:0][2:0]       req_op  = '0;
    logic [WIDTH-1:0]      mdu_res = '0;
    logic                  mdu_vld_out = 1'b0;

    logic [1:0]            req_rdy;
    logic [1:0]            rsp_vld;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic [WIDTH-1:0]      mdu_srcA;
    logic [WIDTH-1:0]      mdu_srcB;
    logic [2:0]            mdu_op;
    logic                  mdu_vld_in;
    logic                  mdu_clear;
    logic                  busy;

    sr_mdu_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .req_clr     (req_clr),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .mdu_srcA    (mdu_srcA),
        .mdu_srcB    (mdu_srcB),
        .mdu_op      (mdu_op),
        .mdu_vld_in  (mdu_vld_in),
        .mdu_clear   (mdu_clear),
        .mdu_res     (mdu_res),
        .mdu_vld_out (mdu_vld_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Cycle index: value of cyc during the period following a rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference MDU behaviour (opcode set chosen by the bench).
    function automatic logic [WIDTH-1:0] mdu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            3'd0:    return p[WIDTH-1:0];
            3'd1:    return p[2*WIDTH-1:WIDTH];
            3'd4:    return (b == '0) ? '1 : a / b;
            3'd5:    return (b == '0) ? a : a % b;
            default: return a ^ b;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------
    typedef struct {
        int               owner;
        logic [WIDTH-1:0] data;
        logic             err;
        int               due;
    } rsp_t;

    rsp_t rsp_q[$];
    int   clr_q[$];
    rsp_t mon_e;
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_vld != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_vld", rsp_vld, 2'b00);
                end else begin
                    mon_e = rsp_q.pop_front();
                    chk("rsp_vld_line", rsp_vld, (mon_e.owner == 1) ? 2'b10 : 2'b01);
                    chk("rsp_data", rsp_data, mon_e.data);
                    chk("rsp_err", rsp_err, mon_e.err);
                    chk("rsp_cycle", cyc, mon_e.due);
                end
            end
            if (mdu_clear) begin
                if (clr_q.size() == 0) begin
                    chk("unexpected_mdu_clear", mdu_clear, 1'b0);
                end else begin
                    chk("mdu_clear_cycle", cyc, clr_q.pop_front());
                end
                chk("vld_in_with_clear", mdu_vld_in, 1'b0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    int                    m_pri = 0;   // round-robin pointer of the model
    logic [1:0][WIDTH-1:0] nx_a, nx_b;
    logic [1:0][2:0]       nx_op;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 2; i++) begin
            nx_a[i]  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 20)) : $urandom;
            nx_b[i]  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 20)) : $urandom;
            nx_op[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_rdy",    req_rdy,    2'b00);
        chk("rst_rsp_vld",    rsp_vld,    2'b00);
        chk("rst_rsp_data",   rsp_data,   '0);
        chk("rst_rsp_err",    rsp_err,    1'b0);
        chk("rst_mdu_srcA",   mdu_srcA,   '0);
        chk("rst_mdu_srcB",   mdu_srcB,   '0);
        chk("rst_mdu_op",     mdu_op,     3'd0);
        chk("rst_mdu_vld_in", mdu_vld_in, 1'b0);
        chk("rst_mdu_clear",  mdu_clear,  1'b0);
        chk("rst_busy",       busy,       1'b0);
    endtask

    // Called in an IDLE cycle, #1 after the edge; returns in the next IDLE
    // cycle, #1 after the edge.
    //   mode NORMAL : MDU answers L cycles after the start strobe
    //   mode TIMEOUT: MDU never answers
    //   mode CANCEL : owner cancels in WAIT cycle k (k = -1 means ISSUE);
    //                 collide adds a same-cycle result, late adds a result
    //                 the cycle after the cancel.
    task automatic run_txn(input logic [1:0] vmask, input int mode, input int L,
                           input int k, input bit collide, input bit late, input bit keep);
        int               owner;
        int               t_g;
        int               r_c;
        int               c_c;
        logic [WIDTH-1:0] ea, eb, ed;
        logic [2:0]       eo;

        req_vld = vmask;
        req_a   = nx_a;
        req_b   = nx_b;
        req_op  = nx_op;
        owner   = (vmask == 2'b11) ? m_pri : (vmask[1] ? 1 : 0);
        @(negedge clk);
        chk("req_rdy_grant", req_rdy, (owner == 1) ? 2'b10 : 2'b01);
        t_g   = cyc;
        m_pri = 1 - owner;
        ea = nx_a[owner];
        eb = nx_b[owner];
        eo = nx_op[owner];
        ed = mdu_fn(ea, eb, eo);

        // ISSUE cycle: scramble request inputs and offer a stray result
        step();
        if (!keep) req_vld = 2'b00;
        req_a       = {$urandom, $urandom};
        req_b       = {$urandom, $urandom};
        mdu_vld_out = ($urandom_range(0, 3) == 0);
        mdu_res     = $urandom;
        if (mode == M_CANCEL && k < 0) req_clr[owner] = 1'b1;
        @(negedge clk);
        chk("issue_mdu_vld_in", mdu_vld_in, 1'b1);
        chk("issue_mdu_srcA", mdu_srcA, ea);
        chk("issue_mdu_srcB", mdu_srcB, eb);
        chk("issue_mdu_op", mdu_op, eo);
        chk("issue_busy", busy, 1'b1);
        chk("issue_req_rdy", req_rdy, 2'b00);

        if (mode == M_CANCEL) begin
            c_c = t_g + 2 + k;
            for (int c = t_g + 2; c <= c_c; c++) begin
                step();
                req_clr        = 2'b00;
                req_clr[owner] = (c == c_c);
                mdu_vld_out    = collide && (c == c_c);
                mdu_res        = $urandom;
            end
            clr_q.push_back(c_c + 1);
            step();
            req_clr     = 2'b00;
            mdu_vld_out = late;
            mdu_res     = $urandom;
            @(negedge clk);
            chk("busy_after_cancel", busy, 1'b0);
            step();
            mdu_vld_out = 1'b0;
        end else begin
            r_c = (mode == M_TIMEOUT) ? t_g + 2 + TIMEOUT : t_g + 2 + L;
            if (mode == M_TIMEOUT) begin
                rsp_q.push_back('{owner, '0, 1'b1, r_c});
                clr_q.push_back(r_c);
            end else begin
                rsp_q.push_back('{owner, ed, 1'b0, r_c});
            end
            for (int c = t_g + 2; c < r_c; c++) begin
                step();
                mdu_vld_out        = (mode == M_NORMAL) && (c == t_g + 1 + L);
                mdu_res            = mdu_vld_out ? mdu_fn(mdu_srcA, mdu_srcB, mdu_op) : $urandom;
                req_clr            = 2'b00;
                req_clr[1 - owner] = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("wait_srcA_stable", mdu_srcA, ea);
            end
            step();
            mdu_vld_out = 1'b0;
            req_clr     = 2'($urandom_range(0, 3));
            @(negedge clk);
            chk("resp_busy", busy, 1'b1);
            chk("resp_req_rdy", req_rdy, 2'b00);
            step();
            req_clr = 2'b00;
        end
    endtask

    // Reset pulse in the middle of WAIT: no response, no clear, pointer reset.
    task automatic run_reset_mid();
        rand_ops();
        req_vld = 2'b01;
        req_a   = nx_a;
        req_b   = nx_b;
        req_op  = nx_op;
        @(negedge clk);
        chk("rmid_grant", req_rdy, 2'b01);
        m_pri = 1;
        step();
        req_vld = 2'b00;
        step();
        step();
        step();
        reset_n = 1'b0;
        step();
        @(negedge clk);
        chk_reset_outputs();
        m_pri = 0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 2);
        req_vld = 2'b00;
        for (int i = 0; i < n; i++) begin
            req_clr = 2'($urandom_range(0, 3));
            step();
        end
        req_clr = 2'b00;
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        int vm, md, lat, kk;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        mon_en = 1'b1;
        step();
        reset_n = 1'b1;

        // Contention: both requesters valid continuously from reset
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            run_txn(2'b11, M_NORMAL, $urandom_range(1, 4), 0, 1'b0, 1'b0, 1'b1);
        end
        req_vld = 2'b00;

        // Single op: 6 * 7 with latency 3
        rand_ops();
        nx_a[0]  = 32'd6;
        nx_b[0]  = 32'd7;
        nx_op[0] = 3'd0;
        run_txn(2'b01, M_NORMAL, 3, 0, 1'b0, 1'b0, 1'b0);

        // Cancel by requester 1 two cycles into WAIT, then a late result
        rand_ops();
        run_txn(2'b10, M_CANCEL, 0, 2, 1'b0, 1'b1, 1'b0);

        // Timeout
        rand_ops();
        run_txn(2'b01, M_TIMEOUT, 0, 0, 1'b0, 1'b0, 1'b0);

        // Cancel colliding with a result
        rand_ops();
        run_txn(2'b01, M_CANCEL, 0, 1, 1'b1, 1'b0, 1'b0);

        // Cancel colliding with the timeout
        rand_ops();
        run_txn(2'b10, M_CANCEL, 0, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);

        // Reset mid-WAIT, then both valid: requester 0 must win
        run_reset_mid();
        rand_ops();
        run_txn(2'b11, M_NORMAL, 2, 0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            idle_gap();
            rand_ops();
            vm  = $urandom_range(1, 3);
            md  = $urandom_range(0, 5);
            md  = (md < 3) ? M_NORMAL : ((md == 3) ? M_TIMEOUT : M_CANCEL);
            lat = $urandom_range(1, TIMEOUT);
            kk  = $urandom_range(0, TIMEOUT) - 1;
            run_txn(2'(vm), md, lat, kk,
                    (kk >= 0) && ($urandom_range(0, 1) == 1),
                    1'($urandom_range(0, 1)),
                    (md != M_CANCEL) && ($urandom_range(0, 1) == 1));
        end
        req_vld = 2'b00;

        repeat (4) step();
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("clear_queue_drained", clr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
